// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared defaults and entry attribute type for the reorder buffer
package reorder_buffer_pkg;

    localparam int ROB_DEPTH_DEF = 8;
    localparam int ROB_XLEN_DEF  = 32;
    localparam int ROB_RA_W_DEF  = 5;
    localparam int ROB_N_WB_DEF  = 3;

    // Per-entry instruction attributes captured at issue and replayed at commit.
    typedef struct packed {
        logic w;
        logic load;
        logic store;
        logic jump;
    } rob_attr_t;

endpackage

// File: rtl/reorder_buffer_fwd_search.sv
// rtl/reorder_buffer_fwd_search.sv - youngest-first priority match over the occupied ring window
module reorder_buffer_fwd_search #(
    parameter  int DEPTH = 8,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] match_i,
    input  logic [TAG_W-1:0] head_i,
    input  logic [TAG_W:0]   count_i,
    output logic             hit_o,
    output logic [TAG_W-1:0] idx_o
);

    logic [TAG_W-1:0] pos;
    logic             found;

    // Walk k = 0 (tail-1, youngest) up to count-1 (head, oldest); first match wins.
    always_comb begin
        found = 1'b0;
        idx_o = '0;
        pos   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pos = head_i + count_i[TAG_W-1:0] - TAG_W'(k + 1);
            if (!found && ((TAG_W+1)'(k) < count_i) && match_i[pos]) begin
                found = 1'b1;
                idx_o = pos;
            end
        end
        hit_o = found;
    end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order-commit reorder buffer with out-of-order write-back,
// register forwarding lookup and flush
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter  int DEPTH = ROB_DEPTH_DEF,
    parameter  int XLEN  = ROB_XLEN_DEF,
    parameter  int RA_W  = ROB_RA_W_DEF,
    parameter  int N_WB  = ROB_N_WB_DEF,
    localparam int TAG_W = $clog2(DEPTH),
    localparam int CNT_W = TAG_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic [XLEN-1:0]       alloc_pc,
    input  logic [RA_W-1:0]       alloc_reg,
    input  logic                  alloc_w,
    input  logic                  alloc_load,
    input  logic                  alloc_store,
    input  logic                  alloc_jump,
    output logic [TAG_W-1:0]      alloc_tag,
    input  logic [N_WB-1:0]       wb_valid,
    input  logic [N_WB*TAG_W-1:0] wb_tag,
    input  logic [N_WB*XLEN-1:0]  wb_val,
    input  logic [N_WB-1:0]       wb_exc,
    output logic                  commit_valid,
    input  logic                  commit_ready,
    output logic [XLEN-1:0]       commit_pc,
    output logic [RA_W-1:0]       commit_reg,
    output logic [XLEN-1:0]       commit_val,
    output logic                  commit_w,
    output logic                  commit_load,
    output logic                  commit_store,
    output logic                  commit_jump,
    output logic                  commit_exc,
    output logic [TAG_W-1:0]      commit_tag,
    input  logic                  flush,
    input  logic [RA_W-1:0]       fwd_reg,
    output logic                  fwd_hit,
    output logic                  fwd_done,
    output logic [XLEN-1:0]       fwd_val,
    output logic [CNT_W-1:0]      count
);

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [DEPTH-1:0] exc_q, exc_d;

    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic [RA_W-1:0]  reg_q  [DEPTH];
    logic [XLEN-1:0]  val_q  [DEPTH];
    rob_attr_t        attr_q [DEPTH];

    logic [TAG_W-1:0] wb_tag_a [N_WB];
    logic [XLEN-1:0]  wb_val_a [N_WB];
    logic [N_WB-1:0]  wb_hit;
    logic             wb_dup;

    logic             alloc_fire;
    logic             commit_fire;
    logic [DEPTH-1:0] fwd_match;
    logic             fwd_found;
    logic [TAG_W-1:0] fwd_idx;

    always_comb begin
        for (int i = 0; i < N_WB; i++) begin
            wb_tag_a[i] = wb_tag[i*TAG_W +: TAG_W];
            wb_val_a[i] = wb_val[i*XLEN +: XLEN];
            wb_hit[i]   = wb_valid[i] && valid_q[wb_tag[i*TAG_W +: TAG_W]] && !flush;
        end
    end

    always_comb begin
        wb_dup = 1'b0;
        for (int i = 0; i < N_WB; i++) begin
            for (int j = i + 1; j < N_WB; j++) begin
                if (wb_valid[i] && wb_valid[j] && (wb_tag_a[i] == wb_tag_a[j])) begin
                    wb_dup = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset && !flush) begin
            assert (!wb_dup) else $error("reorder_buffer: two write-back ports target the same tag");
        end
    end

    // Full stays full in a commit cycle: readiness looks only at registered occupancy.
    assign alloc_ready  = (count_q != CNT_W'(DEPTH)) && !flush;
    assign alloc_fire   = alloc_valid && alloc_ready;
    assign commit_valid = (count_q != '0) && done_q[head_q] && !flush;
    assign commit_fire  = commit_valid && commit_ready;

    assign alloc_tag    = tail_q;
    assign count        = count_q;

    assign commit_tag   = head_q;
    assign commit_pc    = pc_q[head_q];
    assign commit_reg   = reg_q[head_q];
    assign commit_val   = val_q[head_q];
    assign commit_w     = attr_q[head_q].w;
    assign commit_load  = attr_q[head_q].load;
    assign commit_store = attr_q[head_q].store;
    assign commit_jump  = attr_q[head_q].jump;
    assign commit_exc   = exc_q[head_q];

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        exc_d   = exc_q;
        for (int i = 0; i < N_WB; i++) begin
            if (wb_hit[i]) begin
                done_d[wb_tag_a[i]] = 1'b1;
                exc_d[wb_tag_a[i]]  = wb_exc[i];
            end
        end
        if (commit_fire) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            exc_d[head_q]   = 1'b0;
        end
        if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            exc_d[tail_q]   = 1'b0;
        end
        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            exc_d   = '0;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (commit_fire) begin
            head_d = head_q + TAG_W'(1);
        end
        if (alloc_fire) begin
            tail_d = tail_q + TAG_W'(1);
        end
        if (alloc_fire && !commit_fire) begin
            count_d = count_q + CNT_W'(1);
        end else if (commit_fire && !alloc_fire) begin
            count_d = count_q - CNT_W'(1);
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
            exc_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            exc_q   <= exc_d;
        end
    end

    // Payload is qualified by the flag vectors, so it carries no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            pc_q[tail_q]   <= alloc_pc;
            reg_q[tail_q]  <= alloc_reg;
            attr_q[tail_q] <= '{w: alloc_w, load: alloc_load, store: alloc_store, jump: alloc_jump};
        end
        for (int i = 0; i < N_WB; i++) begin
            if (wb_hit[i]) begin
                val_q[wb_tag_a[i]] <= wb_val_a[i];
            end
        end
    end

    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            fwd_match[e] = valid_q[e] && attr_q[e].w && (reg_q[e] == fwd_reg) && (fwd_reg != '0);
        end
    end

    reorder_buffer_fwd_search #(
        .DEPTH (DEPTH)
    ) u_fwd_search (
        .match_i (fwd_match),
        .head_i  (head_q),
        .count_i (count_q),
        .hit_o   (fwd_found),
        .idx_o   (fwd_idx)
    );

    assign fwd_hit  = fwd_found;
    assign fwd_done = fwd_found && done_q[fwd_idx];
    assign fwd_val  = fwd_found ? val_q[fwd_idx] : '0;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid, alloc_ready;
    logic [31:0] alloc_pc;
    logic [4:0]  alloc_reg;
    logic        alloc_w, alloc_load, alloc_store, alloc_jump;
    logic [2:0]  alloc_tag;
    logic [2:0]  wb_valid;
    logic [8:0]  wb_tag;
    logic [95:0] wb_val;
    logic [2:0]  wb_exc;
    logic        commit_valid, commit_ready;
    logic [31:0] commit_pc, commit_val;
    logic [4:0]  commit_reg;
    logic        commit_w, commit_load, commit_store, commit_jump, commit_exc;
    logic [2:0]  commit_tag;
    logic        flush;
    logic [4:0]  fwd_reg;
    logic        fwd_hit, fwd_done;
    logic [31:0] fwd_val;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reorder_buffer #(.DEPTH(8), .XLEN(32), .RA_W(5), .N_WB(3)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
        .alloc_reg(alloc_reg), .alloc_w(alloc_w), .alloc_load(alloc_load),
        .alloc_store(alloc_store), .alloc_jump(alloc_jump), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val), .wb_exc(wb_exc),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_pc(commit_pc),
        .commit_reg(commit_reg), .commit_val(commit_val), .commit_w(commit_w),
        .commit_load(commit_load), .commit_store(commit_store), .commit_jump(commit_jump),
        .commit_exc(commit_exc), .commit_tag(commit_tag),
        .flush(flush), .fwd_reg(fwd_reg), .fwd_hit(fwd_hit), .fwd_done(fwd_done),
        .fwd_val(fwd_val), .count(count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alloc_valid = 1'b0; alloc_pc = '0; alloc_reg = '0;
        alloc_w = 1'b0; alloc_load = 1'b0; alloc_store = 1'b0; alloc_jump = 1'b0;
        wb_valid = '0; wb_tag = '0; wb_val = '0; wb_exc = '0;
        commit_ready = 1'b0; flush = 1'b0; fwd_reg = '0;
    endtask

    task automatic set_alloc(input logic [31:0] pc, input logic [4:0] rd, input logic w);
        alloc_valid = 1'b1; alloc_pc = pc; alloc_reg = rd; alloc_w = w;
    endtask

    task automatic set_wb(input int p, input logic [2:0] t, input logic [31:0] v, input logic e);
        wb_valid[p] = 1'b1; wb_tag[p*3 +: 3] = t; wb_val[p*32 +: 32] = v; wb_exc[p] = e;
    endtask

    task automatic do_flush();
        clear_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        tick(); tick();
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %0b exp 1", alloc_ready); end
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL reset_commit_valid got %0b exp 0", commit_valid); end
        checks++; if (alloc_tag !== 3'd0) begin errors++; $display("FAIL reset_alloc_tag got %0d exp 0", alloc_tag); end
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit got %0b exp 0", fwd_hit); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_in_order_commit();
        set_alloc(32'h100, 5'd1, 1'b1); #1;
        checks++; if (alloc_tag !== 3'd0) begin errors++; $display("FAIL io_tag0 got %0d exp 0", alloc_tag); end
        tick();
        set_alloc(32'h104, 5'd2, 1'b1); tick();
        set_alloc(32'h108, 5'd3, 1'b1); tick();
        alloc_valid = 1'b0; #1;
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL io_count3 got %0d exp 3", count); end
        set_wb(2, 3'd2, 32'h22, 1'b0); tick();
        wb_valid = '0; set_wb(1, 3'd1, 32'h11, 1'b0); #1;
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL io_no_commit_before_head got %0b exp 0", commit_valid); end
        tick();
        wb_valid = '0; set_wb(0, 3'd0, 32'h10, 1'b0); #1;
        checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL io_no_wb_bypass got %0b exp 0", commit_valid); end
        tick();
        wb_valid = '0; commit_ready = 1'b1; #1;
        checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL io_c0_valid got %0b exp 1", commit_valid); end
        checks++; if (commit_reg !== 5'd1) begin errors++; $display("FAIL io_c0_reg got %0d exp 1", commit_reg); end
        checks++; if (commit_val !== 32'h10) begin errors++; $display("FAIL io_c0_val got %0h exp 10", commit_val); end
        checks++; if (commit_pc !== 32'h100) begin errors++; $display("FAIL io_c0_pc got %0h exp 100", commit_pc); end
        tick();
        checks++; if (commit_reg !== 5'd2 || commit_val !== 32'h11) begin errors++; $display("FAIL io_c1 got r%0d %0h exp r2 11", commit_reg, commit_val); end
        tick();
        checks++; if (commit_reg !== 5'd3 || commit_val !== 32'h22 || commit_tag !== 3'd2) begin errors++; $display("FAIL io_c2 got r%0d %0h t%0d exp r3 22 t2", commit_reg, commit_val, commit_tag); end
        tick();
        commit_ready = 1'b0; #1;
        checks++; if (commit_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL io_drained got v%0b c%0d exp v0 c0", commit_valid, count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            logic [2:0] exp_tag;
            exp_tag = 3'(3 + i);
            set_alloc(32'h400 + 32'(i * 4), 5'd9, 1'b1); #1;
            checks++; if (alloc_tag !== exp_tag) begin errors++; $display("FAIL full_tag%0d got %0d exp %0d", i, alloc_tag, exp_tag); end
            tick();
        end
        #1;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", count); end
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b exp 0", alloc_ready); end
        set_wb(0, 3'd3, 32'h33, 1'b0); tick();
        wb_valid = '0; commit_ready = 1'b1; #1;
        checks++; if (alloc_ready !== 1'b0 || commit_valid !== 1'b1) begin errors++; $display("FAIL full_commit_cycle got r%0b v%0b exp r0 v1", alloc_ready, commit_valid); end
        tick();
        commit_ready = 1'b0; #1;
        checks++; if (count !== 4'd7 || alloc_ready !== 1'b1 || alloc_tag !== 3'd3) begin errors++; $display("FAIL full_after_commit got c%0d r%0b t%0d exp c7 r1 t3", count, alloc_ready, alloc_tag); end
        tick();
        alloc_valid = 1'b0; #1;
        checks++; if (count !== 4'd8 || alloc_ready !== 1'b0) begin errors++; $display("FAIL full_refill got c%0d r%0b exp c8 r0", count, alloc_ready); end
        flush = 1'b1; #1;
        checks++; if (alloc_ready !== 1'b0 || commit_valid !== 1'b0) begin errors++; $display("FAIL full_flush_gate got r%0b v%0b exp 0 0", alloc_ready, commit_valid); end
        do_flush();
    endtask

    task automatic test_stall();
        set_alloc(32'h200, 5'd4, 1'b1); tick();
        set_alloc(32'h204, 5'd5, 1'b1); tick();
        set_alloc(32'h208, 5'd6, 1'b1); tick();
        alloc_valid = 1'b0; set_wb(1, 3'd0, 32'hAB, 1'b0); tick();
        wb_valid = '0; #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (commit_valid !== 1'b1 || commit_val !== 32'hAB || commit_reg !== 5'd4 || commit_tag !== 3'd0 || commit_pc !== 32'h200 || count !== 4'd3)
                begin errors++; $display("FAIL stall_%0d got v%0b %0h r%0d t%0d pc%0h c%0d exp v1 ab r4 t0 pc200 c3", c, commit_valid, commit_val, commit_reg, commit_tag, commit_pc, count); end
            tick();
        end
        commit_ready = 1'b1; tick();
        commit_ready = 1'b0; #1;
        checks++; if (count !== 4'd2 || commit_valid !== 1'b0 || commit_tag !== 3'd1) begin errors++; $display("FAIL stall_release got c%0d v%0b t%0d exp c2 v0 t1", count, commit_valid, commit_tag); end
        do_flush();
    endtask

    task automatic test_forward();
        set_alloc(32'h500, 5'd5, 1'b1); tick();
        set_alloc(32'h504, 5'd5, 1'b1); tick();
        set_alloc(32'h508, 5'd5, 1'b0); tick();
        set_alloc(32'h50C, 5'd0, 1'b1); tick();
        alloc_valid = 1'b0; fwd_reg = 5'd5; #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_done !== 1'b0) begin errors++; $display("FAIL fwd_pending got h%0b d%0b exp h1 d0", fwd_hit, fwd_done); end
        fwd_reg = 5'd0; #1;
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_r0 got %0b exp 0", fwd_hit); end
        fwd_reg = 5'd7; #1;
        checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_miss got %0b exp 0", fwd_hit); end
        fwd_reg = 5'd5; set_wb(2, 3'd1, 32'd42, 1'b0); tick();
        wb_valid = '0; #1;
        checks++; if (fwd_hit !== 1'b1 || fwd_done !== 1'b1 || fwd_val !== 32'd42) begin errors++; $display("FAIL fwd_done got h%0b d%0b %0d exp h1 d1 42", fwd_hit, fwd_done, fwd_val); end
        set_wb(0, 3'd0, 32'd7, 1'b0); tick();
        wb_valid = '0; #1;
        checks++; if (fwd_val !== 32'd42) begin errors++; $display("FAIL fwd_youngest got %0d exp 42", fwd_val); end
        do_flush();
    endtask

    task automatic test_exception_flush();
        set_alloc(32'h300, 5'd8, 1'b1); tick();
        alloc_valid = 1'b0; set_wb(0, 3'd0, 32'h55, 1'b1); tick();
        wb_valid = '0; #1;
        checks++; if (commit_valid !== 1'b1 || commit_exc !== 1'b1) begin errors++; $display("FAIL exc_report got v%0b e%0b exp 1 1", commit_valid, commit_exc); end
        set_alloc(32'h304, 5'd9, 1'b1); set_wb(0, 3'd0, 32'h66, 1'b0); flush = 1'b1; commit_ready = 1'b1; #1;
        checks++; if (alloc_ready !== 1'b0 || commit_valid !== 1'b0) begin errors++; $display("FAIL exc_flush_gate got r%0b v%0b exp 0 0", alloc_ready, commit_valid); end
        tick();
        clear_inputs(); #1;
        checks++; if (count !== 4'd0 || alloc_tag !== 3'd0 || commit_valid !== 1'b0) begin errors++; $display("FAIL exc_flushed got c%0d t%0d v%0b exp 0 0 0", count, alloc_tag, commit_valid); end
        set_alloc(32'h300, 5'd8, 1'b1); #1;
        checks++; if (alloc_tag !== 3'd0) begin errors++; $display("FAIL exc_next_tag got %0d exp 0", alloc_tag); end
        tick();
        alloc_valid = 1'b0; #1;
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL exc_count1 got %0d exp 1", count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            set_alloc(32'h600 + 32'(i * 4), 5'(10 + i), 1'b1); tick();
        end
        alloc_valid = 1'b0; set_wb(0, 3'd0, 32'h77, 1'b0); tick();
        wb_valid = '0; fwd_reg = 5'd8; #1;
        checks++; if (count !== 4'd5 || commit_valid !== 1'b1 || fwd_hit !== 1'b1) begin errors++; $display("FAIL rm_pre got c%0d v%0b h%0b exp 5 1 1", count, commit_valid, fwd_hit); end
        reset = 1'b0; #1;
        checks++; if (count !== 4'd0 || alloc_ready !== 1'b1 || commit_valid !== 1'b0 || alloc_tag !== 3'd0 || fwd_hit !== 1'b0)
            begin errors++; $display("FAIL rm_async got c%0d r%0b v%0b t%0d h%0b exp 0 1 0 0 0", count, alloc_ready, commit_valid, alloc_tag, fwd_hit); end
        tick();
        reset = 1'b1; tick();
        set_alloc(32'h700, 5'd3, 1'b1); #1;
        checks++; if (alloc_tag !== 3'd0 || count !== 4'd0) begin errors++; $display("FAIL rm_after got t%0d c%0d exp 0 0", alloc_tag, count); end
        tick();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_in_order_commit();
        test_full();
        test_stall();
        test_forward();
        test_exception_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
